// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply,
// optional signed saturation on ADD/SUB, and {V,C,N,Z} status flags.
module alu_mc #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              i_SCLK,
    input  logic              i_RESETB,
    input  logic              i_START,
    input  logic [2:0]        i_OP,
    input  logic              i_SAT,
    input  logic [DATA_W-1:0] i_RX,
    input  logic [DATA_W-1:0] i_RY,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic [DATA_W-1:0] o_RESULT,
    output logic [DATA_W-1:0] o_RESULT_HI,
    output logic [3:0]        o_FLAGS
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    localparam logic [2:0] OP_CMPZ = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic                sat_q;
    logic [DATA_W-1:0]   x_q, y_q;
    logic [DATA_W-1:0]   prod_hi_q, prod_lo_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                last_iter;

    logic [DATA_W:0]     add_w, sub_w;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c, alu_v;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
    assign o_BUSY    = (state_q != S_IDLE);
    assign o_DONE    = (state_q == S_DONE);

    always_ff @(posedge i_SCLK or negedge i_RESETB) begin
        if (!i_RESETB)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_START) state_d = (i_OP == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_MUL:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // SUB is X + ~Y + 1, so the carry out is the inverted borrow.
    assign add_w = {1'b0, x_q} + {1'b0, y_q};
    assign sub_w = {1'b0, x_q} + {1'b0, ~y_q} + (DATA_W+1)'(1);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_CMPZ: alu_res = {{(DATA_W-1){1'b0}}, (x_q == '0)};
            OP_ADD: begin
                alu_res = add_w[DATA_W-1:0];
                alu_c   = add_w[DATA_W];
                alu_v   = (x_q[DATA_W-1] == y_q[DATA_W-1]) && (add_w[DATA_W-1] != x_q[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[DATA_W-1:0];
                alu_c   = sub_w[DATA_W];
                alu_v   = (x_q[DATA_W-1] != y_q[DATA_W-1]) && (sub_w[DATA_W-1] != x_q[DATA_W-1]);
            end
            OP_AND:  alu_res = x_q & y_q;
            OP_OR:   alu_res = x_q | y_q;
            OP_XOR:  alu_res = x_q ^ y_q;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(x_q) < $signed(y_q))};
            default: alu_res = '0;
        endcase
        // Overflow direction follows the sign of X for both ADD and SUB.
        if (sat_q && alu_v)
            alu_res = x_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    // One shift-add step: conditionally add X into the high half, then shift the pair right.
    assign mul_sum  = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, x_q} : '0);
    assign mul_next = {mul_sum, prod_lo_q[DATA_W-1:1]};

    always_ff @(posedge i_SCLK or negedge i_RESETB) begin
        if (!i_RESETB) begin
            op_q        <= '0;
            sat_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            prod_hi_q   <= '0;
            prod_lo_q   <= '0;
            cnt_q       <= '0;
            o_RESULT    <= '0;
            o_RESULT_HI <= '0;
            o_FLAGS     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_START) begin
                        op_q      <= i_OP;
                        sat_q     <= i_SAT;
                        x_q       <= i_RX;
                        y_q       <= i_RY;
                        prod_hi_q <= '0;
                        prod_lo_q <= i_RY;
                        cnt_q     <= '0;
                    end
                end
                S_EXEC: begin
                    o_RESULT    <= alu_res;
                    o_RESULT_HI <= '0;
                    o_FLAGS     <= {alu_v, alu_c, alu_res[DATA_W-1], (alu_res == '0)};
                end
                S_MUL: begin
                    {prod_hi_q, prod_lo_q} <= mul_next;
                    cnt_q                  <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        o_RESULT    <= mul_next[DATA_W-1:0];
                        o_RESULT_HI <= mul_next[2*DATA_W-1:DATA_W];
                        o_FLAGS     <= {2'b00, mul_next[2*DATA_W-1], (mul_next == '0)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes hand-computed results, a
// monitor pops and compares on every DONE pulse.
module tb_alu_mc;

    typedef struct {
        logic [2:0]  op;
        logic        sat;
        logic [15:0] x, y, res, hi;
        logic [3:0]  flags;
    } vec_t;

    logic        i_SCLK = 1'b0;
    logic        i_RESETB = 1'b0;
    logic        i_START = 1'b0;
    logic [2:0]  i_OP = '0;
    logic        i_SAT = 1'b0;
    logic [15:0] i_RX = '0, i_RY = '0;
    logic        o_BUSY, o_DONE;
    logic [15:0] o_RESULT, o_RESULT_HI;
    logic [3:0]  o_FLAGS;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    vec_t exp_q[$];
    int   done_cyc[$];

    alu_mc #(.DATA_W(16), .CNT_W(5)) dut (
        .i_SCLK(i_SCLK), .i_RESETB(i_RESETB), .i_START(i_START), .i_OP(i_OP),
        .i_SAT(i_SAT), .i_RX(i_RX), .i_RY(i_RY), .o_BUSY(o_BUSY), .o_DONE(o_DONE),
        .o_RESULT(o_RESULT), .o_RESULT_HI(o_RESULT_HI), .o_FLAGS(o_FLAGS)
    );

    always #5 i_SCLK = ~i_SCLK;
    always @(posedge i_SCLK) cyc <= cyc + 1;

    function automatic vec_t mk(logic [2:0] op, logic sat, logic [15:0] x, logic [15:0] y,
                                logic [15:0] res, logic [15:0] hi, logic [3:0] flags);
        vec_t v;
        v.op = op; v.sat = sat; v.x = x; v.y = y; v.res = res; v.hi = hi; v.flags = flags;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge i_SCLK) begin
        if (i_RESETB && o_DONE) begin
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: DONE pulsed with no op outstanding (t=%0t)", $time);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                checkOutput("result", 32'(o_RESULT), 32'(e.res));
                checkOutput("result_hi", 32'(o_RESULT_HI), 32'(e.hi));
                checkOutput("flags", 32'(o_FLAGS), 32'(e.flags));
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int lat, busy_cnt, want;
        @(negedge i_SCLK);
        i_START = 1'b1; i_OP = v.op; i_SAT = v.sat; i_RX = v.x; i_RY = v.y;
        exp_q.push_back(v);
        @(posedge i_SCLK);
        #1;
        i_START = 1'b0;
        i_OP = 3'($urandom); i_SAT = 1'($urandom); i_RX = 16'($urandom); i_RY = 16'($urandom);
        lat = 0; busy_cnt = 0;
        while (lat < 40) begin
            @(negedge i_SCLK);
            lat++;
            if (o_BUSY) busy_cnt++;
            if (o_DONE) break;
        end
        if (lat >= 40)
            $display("[TB] FAIL done_timeout: op=%0d never signalled DONE", v.op);
        // EXEC + DONE for ALU ops; 16 MUL iterations + DONE for multiply.
        want = (v.op == 3'b110) ? 17 : 2;
        checkOutput("done_latency", 32'(lat), 32'(want));
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(want));
        @(negedge i_SCLK);
        checkOutput("busy_after_done", 32'(o_BUSY), 32'd0);
    endtask

    task automatic checkResetOutputs(string tag);
        checkOutput({tag, "_busy"}, 32'(o_BUSY), 32'd0);
        checkOutput({tag, "_done"}, 32'(o_DONE), 32'd0);
        checkOutput({tag, "_result"}, 32'(o_RESULT), 32'd0);
        checkOutput({tag, "_result_hi"}, 32'(o_RESULT_HI), 32'd0);
        checkOutput({tag, "_flags"}, 32'(o_FLAGS), 32'd0);
    endtask

    vec_t vecs[17];
    vec_t bb[4];

    initial begin
        // flags are {V,C,N,Z}
        vecs[0]  = mk(3'b001, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1010);
        vecs[1]  = mk(3'b001, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 4'b1000);
        vecs[2]  = mk(3'b010, 1'b0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0101);
        vecs[3]  = mk(3'b010, 1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 4'b1110);
        vecs[4]  = mk(3'b110, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010);
        vecs[5]  = mk(3'b000, 1'b0, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 4'b0000);
        vecs[6]  = mk(3'b000, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
        vecs[7]  = mk(3'b111, 1'b0, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 4'b0000);
        vecs[8]  = mk(3'b111, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 4'b0001);
        vecs[9]  = mk(3'b101, 1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A, 16'h0000, 4'b0000);
        vecs[10] = mk(3'b011, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000);
        vecs[11] = mk(3'b100, 1'b0, 16'h8000, 16'h0001, 16'h8001, 16'h0000, 4'b0010);
        vecs[12] = mk(3'b001, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0101);
        vecs[13] = mk(3'b010, 1'b0, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 4'b0010);
        vecs[14] = mk(3'b110, 1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000);
        vecs[15] = mk(3'b110, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0001);
        vecs[16] = mk(3'b110, 1'b0, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 4'b0000);

        bb[0] = mk(3'b001, 1'b0, 16'h1000, 16'h0234, 16'h1234, 16'h0000, 4'b0000);
        bb[1] = mk(3'b110, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 4'b0000);
        bb[2] = mk(3'b101, 1'b0, 16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 4'b0000);
        bb[3] = mk(3'b010, 1'b0, 16'h0010, 16'h0001, 16'h000F, 16'h0000, 4'b0100);

        #2;
        checkResetOutputs("por");
        repeat (3) @(negedge i_SCLK);
        i_RESETB = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Abort a multiply mid-way; no DONE may follow and outputs clear.
        @(negedge i_SCLK);
        i_START = 1'b1; i_OP = 3'b110; i_RX = 16'hFFFF; i_RY = 16'hFFFF;
        @(posedge i_SCLK);
        #1 i_START = 1'b0;
        repeat (5) @(negedge i_SCLK);
        i_RESETB = 1'b0;
        #1;
        checkResetOutputs("midmul_reset");
        repeat (2) @(negedge i_SCLK);
        i_RESETB = 1'b1;
        repeat (25) @(negedge i_SCLK);
        checkOutput("post_abort_busy", 32'(o_BUSY), 32'd0);
        applyStimulus(mk(3'b001, 1'b0, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 4'b0000));

        // START held high with operands scrambled while busy.
        begin
            int idx, guard;
            done_cyc.delete();
            idx = 0; guard = 0;
            while (idx < 4 && guard < 200) begin
                @(negedge i_SCLK);
                guard++;
                i_START = 1'b1;
                if (!o_BUSY) begin
                    i_OP = bb[idx].op; i_SAT = bb[idx].sat; i_RX = bb[idx].x; i_RY = bb[idx].y;
                    exp_q.push_back(bb[idx]);
                    idx++;
                end else begin
                    i_OP = 3'($urandom); i_SAT = 1'($urandom);
                    i_RX = 16'($urandom); i_RY = 16'($urandom);
                end
            end
            @(posedge i_SCLK);
            #1;
            i_START = 1'b0; i_RX = 16'($urandom); i_RY = 16'($urandom);
            guard = 0;
            while (exp_q.size() != 0 && guard < 100) begin
                @(negedge i_SCLK);
                guard++;
            end
            repeat (3) @(negedge i_SCLK);
            checkOutput("b2b_launched", 32'(idx), 32'd4);
            checkOutput("b2b_done_count", 32'(done_cyc.size()), 32'd4);
            // Launch edges 0,3,21,24 give DONE spacing 18,3,3.
            if (done_cyc.size() == 4) begin
                checkOutput("b2b_gap0", 32'(done_cyc[1] - done_cyc[0]), 32'd18);
                checkOutput("b2b_gap1", 32'(done_cyc[2] - done_cyc[1]), 32'd3);
                checkOutput("b2b_gap2", 32'(done_cyc[3] - done_cyc[2]), 32'd3);
            end
        end

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
